// File: rtl/xentry_pkg.sv
// xentry_pkg: memory operation and requester types shared by the cache controllers
package xentry_pkg;
  typedef enum logic [1:0] {LOAD, STORE, MO_UNKNOWN} memory_operation_e;
  typedef enum logic {ICACHE, DCACHE} requester_e;
endpackage

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin arbiter granting icache/dcache beats onto a single L2 port
module l1_l2_arbiter
  import xentry_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_req_valid,
  input  memory_operation_e icache_req_type,
  input  logic [XLEN-1:0]   icache_req_address,
  input  logic [XLEN-1:0]   icache_req_store_word,
  output logic              icache_req_fulfilled,
  input  logic              dcache_req_valid,
  input  memory_operation_e dcache_req_type,
  input  logic [XLEN-1:0]   dcache_req_address,
  input  logic [XLEN-1:0]   dcache_req_store_word,
  output logic              dcache_req_fulfilled,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [XLEN-1:0]   l2_req_address,
  output logic [XLEN-1:0]   l2_req_store_word,
  input  logic              l2_req_fulfilled,
  input  logic [XLEN-1:0]   l2_loaded_word,
  output logic [XLEN-1:0]   loaded_word
);
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_I, ST_GRANT_D} state_e;
  state_e     state, state_nxt;
  requester_e last_grant;
  assign loaded_word = l2_loaded_word;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= DCACHE;
    end else begin
      state      <= state_nxt;
      last_grant <= state_nxt == ST_GRANT_I ? ICACHE : state_nxt == ST_GRANT_D ? DCACHE : last_grant;
    end
  end
  always_comb begin
    state_nxt            = state;
    l2_req_valid         = 1'b0;
    l2_req_type          = LOAD;
    l2_req_address       = '0;
    l2_req_store_word    = '0;
    icache_req_fulfilled = 1'b0;
    dcache_req_fulfilled = 1'b0;
    case (state)
      ST_IDLE: state_nxt = (icache_req_valid && (!dcache_req_valid || last_grant == DCACHE)) ? ST_GRANT_I :
                           dcache_req_valid ? ST_GRANT_D : ST_IDLE;
      ST_GRANT_I: begin
        state_nxt            = icache_req_valid ? ST_GRANT_I : dcache_req_valid ? ST_GRANT_D : ST_IDLE;
        l2_req_valid         = icache_req_valid;
        l2_req_type          = icache_req_type;
        l2_req_address       = icache_req_address;
        l2_req_store_word    = icache_req_store_word;
        icache_req_fulfilled = l2_req_fulfilled && icache_req_valid;
      end
      ST_GRANT_D: begin
        state_nxt            = dcache_req_valid ? ST_GRANT_D : icache_req_valid ? ST_GRANT_I : ST_IDLE;
        l2_req_valid         = dcache_req_valid;
        l2_req_type          = dcache_req_type;
        l2_req_address       = dcache_req_address;
        l2_req_store_word    = dcache_req_store_word;
        dcache_req_fulfilled = l2_req_fulfilled && dcache_req_valid;
      end
      default: begin
        state_nxt            = state_e'('x);
        l2_req_valid         = 1'bx;
        l2_req_type          = memory_operation_e'('x);
        l2_req_address       = 'x;
        l2_req_store_word    = 'x;
        icache_req_fulfilled = 1'bx;
        dcache_req_fulfilled = 1'bx;
      end
    endcase
  end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed self-checking bench for l1_l2_arbiter
module tb_l1_l2_arbiter;
  import xentry_pkg::*;
  localparam int XLEN = 32;
  logic              clk = 1'b0;
  logic              reset_n;
  logic              icache_req_valid, dcache_req_valid;
  memory_operation_e icache_req_type, dcache_req_type, l2_req_type;
  logic [XLEN-1:0]   icache_req_address, icache_req_store_word;
  logic [XLEN-1:0]   dcache_req_address, dcache_req_store_word;
  logic              icache_req_fulfilled, dcache_req_fulfilled;
  logic              l2_req_valid, l2_req_fulfilled;
  logic [XLEN-1:0]   l2_req_address, l2_req_store_word, l2_loaded_word, loaded_word;
  logic              l2_auto, l2_manual;
  logic [1:0]        cnt = '0;
  int                checks = 0;
  int                errors = 0;

  l1_l2_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_req_valid(icache_req_valid), .icache_req_type(icache_req_type),
    .icache_req_address(icache_req_address), .icache_req_store_word(icache_req_store_word),
    .icache_req_fulfilled(icache_req_fulfilled),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_address(dcache_req_address), .dcache_req_store_word(dcache_req_store_word),
    .dcache_req_fulfilled(dcache_req_fulfilled),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type),
    .l2_req_address(l2_req_address), .l2_req_store_word(l2_req_store_word),
    .l2_req_fulfilled(l2_req_fulfilled), .l2_loaded_word(l2_loaded_word),
    .loaded_word(loaded_word)
  );

  always #5 clk = ~clk;

  // L2 model: in auto mode each beat completes on its third presented cycle
  always @(posedge clk)
    if (!l2_auto || !l2_req_valid || l2_req_fulfilled) cnt <= '0;
    else cnt <= cnt + 2'd1;
  assign l2_req_fulfilled = l2_auto ? (l2_req_valid && cnt == 2'd2) : l2_manual;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    icache_req_valid = 1'b0; icache_req_type = LOAD; icache_req_address = '0; icache_req_store_word = '0;
    dcache_req_valid = 1'b0; dcache_req_type = LOAD; dcache_req_address = '0; dcache_req_store_word = '0;
    l2_auto = 1'b0; l2_manual = 1'b0; l2_loaded_word = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    icache_req_valid = 1'b1; dcache_req_valid = 1'b1;
    icache_req_address = 32'h55; dcache_req_address = 32'h66;
    dcache_req_store_word = 32'h77; dcache_req_type = STORE;
    l2_auto = 1'b0; l2_manual = 1'b1;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", l2_req_valid); end
    checks++; if (icache_req_fulfilled !== 1'b0) begin errors++; $display("FAIL reset_ifulfilled got %b exp 0", icache_req_fulfilled); end
    checks++; if (dcache_req_fulfilled !== 1'b0) begin errors++; $display("FAIL reset_dfulfilled got %b exp 0", dcache_req_fulfilled); end
    checks++; if (l2_req_type !== LOAD) begin errors++; $display("FAIL reset_type got %0d exp %0d", l2_req_type, LOAD); end
    checks++; if (l2_req_address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", l2_req_address); end
    checks++; if (l2_req_store_word !== 32'h0) begin errors++; $display("FAIL reset_store got %h exp 0", l2_req_store_word); end
  endtask

  task automatic test_dcache_burst();
    int beat = 0, cyc = 0, first_valid = -1, fulcnt = 0;
    bit ifulseen = 0, grant_lost = 0, type_ok = 0, f;
    do_reset();
    dcache_req_valid = 1'b1; dcache_req_type = STORE;
    dcache_req_address = 32'h100; dcache_req_store_word = 32'hA000;
    l2_auto = 1'b1;
    while (beat < 8 && cyc < 100) begin
      @(negedge clk);
      if (l2_req_valid && first_valid < 0) first_valid = cyc;
      if (icache_req_fulfilled) ifulseen = 1;
      if (cyc >= 1 && (!l2_req_valid || l2_req_address !== dcache_req_address)) grant_lost = 1;
      if (beat == 4 && l2_req_type === LOAD) type_ok = 1;
      f = dcache_req_fulfilled;
      if (f) fulcnt++;
      step();
      cyc++;
      if (f) begin
        beat++;
        if (beat < 8) begin
          dcache_req_type = beat < 4 ? STORE : LOAD;
          dcache_req_address = 32'h100 + beat;
          dcache_req_store_word = 32'hA000 + beat;
        end else dcache_req_valid = 1'b0;
      end
    end
    l2_auto = 1'b0; dcache_req_valid = 1'b0;
    checks++; if (first_valid != 1) begin errors++; $display("FAIL burst_first_valid got %0d exp 1", first_valid); end
    checks++; if (fulcnt != 8) begin errors++; $display("FAIL burst_fulfilled_count got %0d exp 8", fulcnt); end
    checks++; if (ifulseen !== 1'b0) begin errors++; $display("FAIL burst_icache_fulfilled got %b exp 0", ifulseen); end
    checks++; if (grant_lost !== 1'b0) begin errors++; $display("FAIL burst_grant_held got %b exp 0", grant_lost); end
    checks++; if (type_ok !== 1'b1) begin errors++; $display("FAIL burst_type_switch got %b exp 1", type_ok); end
  endtask

  task automatic test_tie();
    do_reset();
    icache_req_valid = 1'b1; icache_req_address = 32'h200; icache_req_store_word = 32'h11; icache_req_type = STORE;
    dcache_req_valid = 1'b1; dcache_req_address = 32'h300;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL tie_latency got %b exp 0", l2_req_valid); end
    step();
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_address !== 32'h200) begin errors++; $display("FAIL tie_grant_i got %b/%h exp 1/200", l2_req_valid, l2_req_address); end
    checks++; if (l2_req_store_word !== 32'h11 || l2_req_type !== STORE) begin errors++; $display("FAIL tie_mux got %h/%0d exp 11/%0d", l2_req_store_word, l2_req_type, STORE); end
    step();
    l2_manual = 1'b1;
    @(negedge clk);
    checks++; if (icache_req_fulfilled !== 1'b1 || dcache_req_fulfilled !== 1'b0) begin errors++; $display("FAIL tie_fulfilled got %b%b exp 10", icache_req_fulfilled, dcache_req_fulfilled); end
    step();
    l2_manual = 1'b0; icache_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL tie_drop_cycle got %b exp 0", l2_req_valid); end
    step();
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_address !== 32'h300) begin errors++; $display("FAIL tie_no_idle_gap got %b/%h exp 1/300", l2_req_valid, l2_req_address); end
    step();
    dcache_req_valid = 1'b0;
  endtask

  task automatic test_alternate();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      icache_req_valid = 1'b1; icache_req_address = 32'h700 + r;
      dcache_req_valid = 1'b1; dcache_req_address = 32'h800 + r;
      @(negedge clk);
      step();
      l2_manual = 1'b1;
      @(negedge clk);
      if (r % 2 == 0) begin
        checks++; if (l2_req_address !== 32'h700 + r || icache_req_fulfilled !== 1'b1 || dcache_req_fulfilled !== 1'b0) begin
          errors++; $display("FAIL alt_round%0d_icache got %h/%b%b exp %h/10", r, l2_req_address, icache_req_fulfilled, dcache_req_fulfilled, 32'h700 + r); end
      end else begin
        checks++; if (l2_req_address !== 32'h800 + r || dcache_req_fulfilled !== 1'b1 || icache_req_fulfilled !== 1'b0) begin
          errors++; $display("FAIL alt_round%0d_dcache got %h/%b%b exp %h/01", r, l2_req_address, icache_req_fulfilled, dcache_req_fulfilled, 32'h800 + r); end
      end
      step();
      icache_req_valid = 1'b0; dcache_req_valid = 1'b0; l2_manual = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL alt_round%0d_idle got %b exp 0", r, l2_req_valid); end
      step();
    end
  endtask

  task automatic test_preempt();
    int beat = 0, cyc = 0;
    bit bad_f = 0, bad_a = 0, f;
    do_reset();
    dcache_req_valid = 1'b1; dcache_req_type = STORE; dcache_req_address = 32'h400;
    icache_req_address = 32'h500;
    l2_auto = 1'b1;
    while (beat < 4 && cyc < 100) begin
      @(negedge clk);
      if (icache_req_fulfilled) bad_f = 1;
      if (l2_req_valid && l2_req_address === 32'h500) bad_a = 1;
      f = dcache_req_fulfilled;
      step();
      cyc++;
      if (cyc == 2) icache_req_valid = 1'b1;
      if (f) begin
        beat++;
        dcache_req_address = 32'h400 + beat;
        if (beat == 4) dcache_req_valid = 1'b0;
      end
    end
    checks++; if (beat != 4) begin errors++; $display("FAIL preempt_burst_done got %0d exp 4", beat); end
    checks++; if (bad_f !== 1'b0) begin errors++; $display("FAIL preempt_icache_fulfilled got %b exp 0", bad_f); end
    checks++; if (bad_a !== 1'b0) begin errors++; $display("FAIL preempt_icache_address got %b exp 0", bad_a); end
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_address !== 32'h500) begin errors++; $display("FAIL preempt_handover got %b/%h exp 1/500", l2_req_valid, l2_req_address); end
    l2_auto = 1'b0;
    step();
    icache_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int beat = 0, cyc = 0;
    bit f;
    do_reset();
    dcache_req_valid = 1'b1; dcache_req_type = STORE; dcache_req_address = 32'h900;
    l2_auto = 1'b1;
    while (beat < 2 && cyc < 100) begin
      @(negedge clk);
      f = dcache_req_fulfilled;
      step();
      cyc++;
      if (f) begin beat++; dcache_req_address = 32'h900 + beat; end
    end
    checks++; if (beat != 2 || l2_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_burst got %0d/%b exp 2/1", beat, l2_req_valid); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (l2_req_valid !== 1'b0 || l2_req_address !== 32'h0) begin errors++; $display("FAIL rstmid_async got %b/%h exp 0/0", l2_req_valid, l2_req_address); end
    checks++; if (dcache_req_fulfilled !== 1'b0 || l2_req_type !== LOAD) begin errors++; $display("FAIL rstmid_outputs got %b/%0d exp 0/%0d", dcache_req_fulfilled, l2_req_type, LOAD); end
    l2_auto = 1'b0; dcache_req_valid = 1'b0;
    icache_req_valid = 1'b1; icache_req_address = 32'h600;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release_idle got %b exp 0", l2_req_valid); end
    step();
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_address !== 32'h600) begin errors++; $display("FAIL rstmid_regrant got %b/%h exp 1/600", l2_req_valid, l2_req_address); end
    step();
    icache_req_valid = 1'b0;
  endtask

  task automatic test_idle_fulfill();
    do_reset();
    l2_manual = 1'b1; l2_loaded_word = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (icache_req_fulfilled !== 1'b0 || dcache_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0) begin
      errors++; $display("FAIL idle_pulse got %b%b%b exp 000", icache_req_fulfilled, dcache_req_fulfilled, l2_req_valid); end
    checks++; if (loaded_word !== 32'hDEADBEEF) begin errors++; $display("FAIL loaded_word got %h exp deadbeef", loaded_word); end
    step();
    l2_loaded_word = 32'h12345678;
    @(negedge clk);
    checks++; if (icache_req_fulfilled !== 1'b0 || dcache_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0) begin
      errors++; $display("FAIL idle_pulse2 got %b%b%b exp 000", icache_req_fulfilled, dcache_req_fulfilled, l2_req_valid); end
    checks++; if (loaded_word !== 32'h12345678) begin errors++; $display("FAIL loaded_word2 got %h exp 12345678", loaded_word); end
    step();
    l2_manual = 1'b0;
    icache_req_valid = 1'b1; icache_req_address = 32'hA00;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_state_change got %b exp 0", l2_req_valid); end
    step();
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_address !== 32'hA00) begin errors++; $display("FAIL idle_then_grant got %b/%h exp 1/a00", l2_req_valid, l2_req_address); end
    step();
    icache_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dcache_burst();
    test_tie();
    test_alternate();
    test_preempt();
    test_reset_mid();
    test_idle_fulfill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
